// File: rtl/seq_divider_pkg.sv
// div_pkg: shared FSM encoding, default width and magnitude helper for seq_divider
package div_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

    function automatic logic [DEF_WIDTH-1:0] abs_mag(input logic [DEF_WIDTH-1:0] x);
        return x[DEF_WIDTH-1] ? -x : x;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between the operand path and seq_divider; SEQ_DIVIDER_UNSIGNED_EN adds is_unsigned
interface seq_divider_if #(parameter int WIDTH = 32);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, dividend, divisor,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
        output is_unsigned,
`endif
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, dividend, divisor,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
        input  is_unsigned,
`endif
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division iteration on unsigned magnitudes
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] diff;
    logic             ge;

    // shift the next dividend bit into the remainder, then trial-subtract with a spare sign bit
    always_comb begin
        sh      = {rem, quo[WIDTH-1]};
        diff    = {1'b0, sh} - {2'b00, divisor_mag};
        ge      = !diff[WIDTH+1];
        rem_nxt = WIDTH'(ge ? diff : {1'b0, sh});
        quo_nxt = {quo[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multicycle signed restoring divider (DIV) with div-by-zero flag; SEQ_DIVIDER_UNSIGNED_EN adds DIVU
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic             uns;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
    assign uns = bus.is_unsigned;
`else
    assign uns = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem_q),
        .quo         (quo_q),
        .divisor_mag (dvs_q),
        .rem_nxt     (step_rem),
        .quo_nxt     (step_quo)
    );

    // next-state: load magnitudes in IDLE, iterate in CALC, publish results leaving FINISH
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (state_q == IDLE) begin
            if (bus.start && !done_q) begin
                rem_d     = '0;
                quo_d     = uns ? bus.dividend : abs_mag(bus.dividend);
                dvs_d     = uns ? bus.divisor : abs_mag(bus.divisor);
                cnt_d     = CNT_W'(WIDTH);
                neg_quo_d = !uns && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                neg_rem_d = !uns && bus.dividend[WIDTH-1];
                zero_d    = bus.divisor == '0;
                state_d   = zero_d ? FINISH : CALC;
            end
        end else if (state_q == CALC) begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = cnt_q == CNT_W'(1) ? FINISH : CALC;
        end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            dz_d    = zero_q;
            hi_d    = zero_q ? hi_q : (neg_rem_q ? -rem_q : rem_q);
            lo_d    = zero_q ? lo_q : (neg_quo_q ? -quo_q : quo_q);
        end
        busy_d = state_d != IDLE;
    end

    // state and registered outputs, cleared immediately by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider; stimulus pushes expectations, a monitor checks each done pulse
module tb_seq_divider;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          issue;
        int          lat;
    } exp_t;

    logic  clk;
    logic  reset;
    exp_t  sb[$];
    exp_t  e;
    int    edge_cnt  = 0;
    int    done_cnt  = 0;
    int    pushed    = 0;
    int    pass_cnt  = 0;
    int    total_cnt = 0;
    int    busy_cycles;

    seq_divider_if #(.WIDTH(32)) bus_if ();

    seq_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] elo,
                         input logic [31:0] ehi, input logic edz, input bit track);
        @(negedge clk);
        bus_if.dividend = a;
        bus_if.divisor  = b;
        bus_if.start    = 1'b1;
        if (track) begin
            sb.push_back('{elo, ehi, edz, edge_cnt + 1, edz ? 2 : 34});
            pushed++;
        end
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("completion_pending", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        edge_cnt++;
        #1;
        if (bus_if.done) begin
            done_cnt++;
            check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("lo", 64'(bus_if.lo), 64'(e.lo));
                check("hi", 64'(bus_if.hi), 64'(e.hi));
                check("div_zero", 64'(bus_if.div_zero), 64'(e.dz));
                check("latency", 64'(edge_cnt - e.issue + 1), 64'(e.lat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset           = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
        bus_if.is_unsigned = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_flags", 64'({bus_if.busy, bus_if.done, bus_if.div_zero}), 64'd0);
        check("rst_hi", 64'(bus_if.hi), 64'd0);
        check("rst_lo", 64'(bus_if.lo), 64'd0);
        reset = 1'b1;

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);                         wait_idle();
        issue(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b1);        wait_idle();
        issue(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b1);                wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);    wait_idle();
        issue(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b1);                            wait_idle();
        issue(-32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b1);                wait_idle();
        issue(32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1);                  wait_idle();

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);                         wait_idle();
        issue(32'd42, 32'd0, 32'd14, 32'd2, 1'b1, 1'b1);
        busy_cycles = int'(bus_if.busy);
        repeat (4) begin
            @(negedge clk);
            busy_cycles += int'(bus_if.busy);
        end
        check("dz_busy_cycles", 64'(busy_cycles), 64'd1);
        wait_idle();

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        for (int i = 0; i < 60 && !bus_if.done; i++) @(negedge clk);
        check("done_seen", 64'(bus_if.done), 64'd1);
        bus_if.dividend = 32'd50;
        bus_if.divisor  = 32'd5;
        bus_if.start    = 1'b1;
        @(negedge clk);
        bus_if.dividend = 32'd9;
        bus_if.divisor  = 32'd3;
        sb.push_back('{32'd3, 32'd0, 1'b0, edge_cnt + 1, 34});
        pushed++;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_idle();

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        bus_if.dividend = 32'd9;
        bus_if.divisor  = 32'd3;
        bus_if.start    = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (14) @(negedge clk);
        bus_if.dividend = 32'hFFFF_FFFF;
        bus_if.divisor  = 32'd0;
        bus_if.start    = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_idle();

        issue(-32'sd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        check("busy_mid_op", 64'(bus_if.busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_flags", 64'({bus_if.busy, bus_if.done, bus_if.div_zero}), 64'd0);
        check("async_rst_hi", 64'(bus_if.hi), 64'd0);
        check("async_rst_lo", 64'(bus_if.lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);                            wait_idle();

`ifdef SEQ_DIVIDER_UNSIGNED_EN
        bus_if.is_unsigned = 1'b1;
        issue(32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1);            wait_idle();
        issue(32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 32'd5, 1'b0, 1'b1);           wait_idle();
        bus_if.is_unsigned = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("done_pulses", 64'(done_cnt), 64'(pushed));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
